// File: rtl/weight_update_seq.sv
// Tap-weight store and sequential updater for the adaptive filter.
// Holds NTAPS signed weights and applies one streamed update term per accepted
// beat (W += U or W -= U for the whole batch). The filter reads the weights
// through a combinational port.
module weight_update_seq #(
  parameter int WD    = 10,
  parameter int NTAPS = 15,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          sg,
  input  logic          upd_valid,
  input  logic [WD-1:0] upd_data,
  output logic          upd_ready,
  output logic          busy,
  output logic          done,
  output logic          ovf,
  input  logic [AW-1:0] rd_addr,
  output logic [WD-1:0] rd_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [AW-1:0] LAST_IDX = AW'(NTAPS - 1);

  logic [1:0]    state;
  logic [AW-1:0] idx;
  logic          sg_q;
  logic          ovf_q;
  logic [WD-1:0] w [NTAPS];

  logic          accept;
  logic [WD-1:0] cur_w;
  logic [WD-1:0] new_w;
  logic          beat_ovf;

  assign upd_ready = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign ovf       = ovf_q;
  assign accept    = upd_ready & upd_valid;

  // Read-modify-write datapath for the tap currently being updated.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    cur_w    = '0;
    new_w    = '0;
    beat_ovf = 1'b0;
    cur_w    = w[idx];
    if (sg_q) begin
      new_w    = cur_w - upd_data;
      beat_ovf = (cur_w[WD-1] != upd_data[WD-1]) && (new_w[WD-1] != cur_w[WD-1]);
    end else begin
      new_w    = cur_w + upd_data;
      beat_ovf = (cur_w[WD-1] == upd_data[WD-1]) && (new_w[WD-1] != cur_w[WD-1]);
    end
  end

  // Batch sequencer: IDLE -> RUN (one tap per accepted beat) -> DONE -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      sg_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sg_q  <= sg;
            idx   <= '0;
            ovf_q <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (beat_ovf) ovf_q <= 1'b1;
            idx <= idx + 1'b1;
            if (idx == LAST_IDX) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Weight store: written back one tap per accepted beat, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this array is reset because an aborted batch must leave all weights
    // at zero; that makes it a flop bank rather than an inferable RAM.
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) w[i] <= '0;
    end else if (accept) begin
      w[idx] <= new_w;
    end
  end

  assign rd_data = (rd_addr <= LAST_IDX) ? w[rd_addr] : '0;

endmodule
